trig_encoder_seq: RTL and testbench

Registered, parametrised successor to the per-CFEB combinational trigger encoder. Encodes per-channel trigger events (pre-LCT, L1A, L1A match, resync) into a 3-bit code carried on the ENC_BIT0/1/2 test-pulse lines. Unlike the combinational version, it:
- holds each code for a programmable number of cycles;
- queues events that arrive while a code is being held, so none are lost;
- flags overruns per channel.
It sits between the L1A/pre-LCT matching logic and the test-pulse output drivers.

---
 rtl/trig_encoder_seq_pkg.sv | 30 +++
 rtl/trig_enc_chan.sv | 118 +++++++++++
 rtl/trig_encoder_seq.sv | 51 +++++
 tb/tb_trig_encoder_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/trig_encoder_seq_pkg.sv
// Shared definitions for the registered trigger encoder: 3-bit event codes,
// per-channel FSM states and the code priority function.
package trig_encoder_seq_pkg;

  localparam logic [2:0] CODE_NONE         = 3'd0;
  localparam logic [2:0] CODE_PRE          = 3'd1;
  localparam logic [2:0] CODE_L1A_PRE      = 3'd2;
  localparam logic [2:0] CODE_L1A_MTCH_PRE = 3'd3;
  localparam logic [2:0] CODE_L1A          = 3'd4;
  localparam logic [2:0] CODE_L1A_MTCH     = 3'd5;
  localparam logic [2:0] CODE_RESYNC       = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } chan_state_e;

  // A match only means something alongside an L1A; on its own it codes as nothing.
  function automatic logic [2:0] enc_code(input logic l1a, input logic mtch, input logic pre);
    logic [2:0] code;
    if (l1a) begin
      if (mtch) code = pre ? CODE_L1A_MTCH_PRE : CODE_L1A_MTCH;
      else      code = pre ? CODE_L1A_PRE      : CODE_L1A;
    end else begin
      code = pre ? CODE_PRE : CODE_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/trig_enc_chan.sv
// One channel of the trigger encoder: pending flags, IDLE/HOLD FSM, hold counter,
// sticky overrun flag and the registered 3-bit output.
module trig_enc_chan
  import trig_encoder_seq_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_mode,
  input  logic       dcfeb_in_use,
  input  logic       snd_win,
  input  logic       resync_rst,
  input  logic       l1acfeb,
  input  logic       pre_lct,
  input  logic       mtch_win,
  input  logic       l1a_match,
  output logic [2:0] enc_bits,
  output logic       ovfl
);

  localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam chan_state_e LOAD_ST = (HOLD > 1) ? ST_HOLD : ST_IDLE;

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    enc_q, enc_d;
  logic          p_pre_q, p_pre_d;
  logic          p_l1a_q, p_l1a_d;
  logic          p_mtch_q, p_mtch_d;
  logic          ovfl_q, ovfl_d;

  logic          eff_pre, eff_l1a, eff_mtch, pt_bit0;
  logic [2:0]    code;

  assign eff_pre  = pre_lct   | p_pre_q;
  assign eff_l1a  = l1acfeb   | p_l1a_q;
  assign eff_mtch = l1a_match | p_mtch_q;
  assign code     = enc_code(eff_l1a, eff_mtch, eff_pre);
  assign pt_bit0  = dcfeb_in_use ? (snd_win ? mtch_win : l1a_match) : pre_lct;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enc_d    = enc_q;
    p_pre_d  = p_pre_q;
    p_l1a_d  = p_l1a_q;
    p_mtch_d = p_mtch_q;
    ovfl_d   = ovfl_q;

    if (!enc_mode) begin
      enc_d    = {resync_rst, l1acfeb, pt_bit0};
      p_pre_d  = 1'b0;
      p_l1a_d  = 1'b0;
      p_mtch_d = 1'b0;
      state_d  = ST_IDLE;
      cnt_d    = '0;
    end else if (resync_rst) begin
      enc_d    = CODE_RESYNC;
      p_pre_d  = 1'b0;
      p_l1a_d  = 1'b0;
      p_mtch_d = 1'b0;
      ovfl_d   = 1'b0;
      cnt_d    = HOLD_LD;
      state_d  = LOAD_ST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          enc_d = code;
          // An orphan match survives a PRE-only code so a later L1A can still pick it up.
          p_pre_d  = 1'b0;
          p_l1a_d  = 1'b0;
          p_mtch_d = eff_mtch & ~eff_l1a;
          if (code != CODE_NONE) begin
            cnt_d   = HOLD_LD;
            state_d = LOAD_ST;
          end
        end
        ST_HOLD: begin
          p_pre_d  = eff_pre;
          p_l1a_d  = eff_l1a;
          p_mtch_d = eff_mtch;
          if ((pre_lct & p_pre_q) | (l1acfeb & p_l1a_q) | (l1a_match & p_mtch_q))
            ovfl_d = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1))
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      enc_q    <= CODE_NONE;
      p_pre_q  <= 1'b0;
      p_l1a_q  <= 1'b0;
      p_mtch_q <= 1'b0;
      ovfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enc_q    <= enc_d;
      p_pre_q  <= p_pre_d;
      p_l1a_q  <= p_l1a_d;
      p_mtch_q <= p_mtch_d;
      ovfl_q   <= ovfl_d;
    end
  end

  assign enc_bits = enc_q;
  assign ovfl     = ovfl_q;

endmodule

// File: rtl/trig_encoder_seq.sv
// Registered trigger encoder: NCH independent channels, each holding its code for HOLD
// cycles and queueing events meanwhile; pass-through when not in encoded mode.
module trig_encoder_seq
  import trig_encoder_seq_pkg::*;
#(
  parameter int NCH  = 5,
  parameter int HOLD = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           ENCODE,
  input  logic           DCFEB_IN_USE,
  input  logic           SND_WIN,
  input  logic           RESYNC_RST,
  input  logic           L1ACFEB,
  input  logic [NCH-1:0] PRE_LCT_OUT,
  input  logic [NCH-1:0] MTCH_WIN_0,
  input  logic [NCH-1:0] L1A_MATCH,
  output logic [NCH-1:0] ENC_BIT0,
  output logic [NCH-1:0] ENC_BIT1,
  output logic [NCH-1:0] ENC_BIT2,
  output logic [NCH-1:0] OVFL
);

  logic       enc_mode;
  logic [2:0] chan_bits [NCH];

  // A DCFEB always gets raw pass-through regardless of the encode request.
  assign enc_mode = ENCODE & ~DCFEB_IN_USE;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    trig_enc_chan #(.HOLD(HOLD)) u_chan (
      .clk         (CLK),
      .rst_n       (RST_N),
      .enc_mode    (enc_mode),
      .dcfeb_in_use(DCFEB_IN_USE),
      .snd_win     (SND_WIN),
      .resync_rst  (RESYNC_RST),
      .l1acfeb     (L1ACFEB),
      .pre_lct     (PRE_LCT_OUT[gi]),
      .mtch_win    (MTCH_WIN_0[gi]),
      .l1a_match   (L1A_MATCH[gi]),
      .enc_bits    (chan_bits[gi]),
      .ovfl        (OVFL[gi])
    );
    assign ENC_BIT0[gi] = chan_bits[gi][0];
    assign ENC_BIT1[gi] = chan_bits[gi][1];
    assign ENC_BIT2[gi] = chan_bits[gi][2];
  end

endmodule

// File: tb/tb_trig_encoder_seq.sv
// Bench for trig_encoder_seq: three instances (HOLD=2,3,4) share stimulus; expected
// per-channel codes come from hand-derived vectors pushed to a scoreboard queue.
module tb_trig_encoder_seq;

  localparam logic [4:0] CI = 5'b00000;
  localparam logic [4:0] CE = 5'b10000;  // ENCODE
  localparam logic [4:0] CD = 5'b01000;  // DCFEB_IN_USE
  localparam logic [4:0] CS = 5'b00100;  // SND_WIN
  localparam logic [4:0] CR = 5'b00010;  // RESYNC_RST
  localparam logic [4:0] CL = 5'b00001;  // L1ACFEB

  typedef struct {
    string       name;
    bit          rst;
    int          dut;
    logic [4:0]  ctl;
    logic [4:0]  pre;
    logic [4:0]  mw;
    logic [4:0]  lm;
    logic [14:0] codes;
    logic [4:0]  ov;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_N, ENCODE, DCFEB_IN_USE, SND_WIN, RESYNC_RST, L1ACFEB;
  logic [4:0] PRE_LCT_OUT, MTCH_WIN_0, L1A_MATCH;
  logic [2:0][4:0] enc0, enc1, enc2, ovfl;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  trig_encoder_seq #(.NCH(5), .HOLD(2)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .ENCODE(ENCODE), .DCFEB_IN_USE(DCFEB_IN_USE),
    .SND_WIN(SND_WIN), .RESYNC_RST(RESYNC_RST), .L1ACFEB(L1ACFEB),
    .PRE_LCT_OUT(PRE_LCT_OUT), .MTCH_WIN_0(MTCH_WIN_0), .L1A_MATCH(L1A_MATCH),
    .ENC_BIT0(enc0[0]), .ENC_BIT1(enc1[0]), .ENC_BIT2(enc2[0]), .OVFL(ovfl[0]));
  trig_encoder_seq #(.NCH(5), .HOLD(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N), .ENCODE(ENCODE), .DCFEB_IN_USE(DCFEB_IN_USE),
    .SND_WIN(SND_WIN), .RESYNC_RST(RESYNC_RST), .L1ACFEB(L1ACFEB),
    .PRE_LCT_OUT(PRE_LCT_OUT), .MTCH_WIN_0(MTCH_WIN_0), .L1A_MATCH(L1A_MATCH),
    .ENC_BIT0(enc0[1]), .ENC_BIT1(enc1[1]), .ENC_BIT2(enc2[1]), .OVFL(ovfl[1]));
  trig_encoder_seq #(.NCH(5), .HOLD(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .ENCODE(ENCODE), .DCFEB_IN_USE(DCFEB_IN_USE),
    .SND_WIN(SND_WIN), .RESYNC_RST(RESYNC_RST), .L1ACFEB(L1ACFEB),
    .PRE_LCT_OUT(PRE_LCT_OUT), .MTCH_WIN_0(MTCH_WIN_0), .L1A_MATCH(L1A_MATCH),
    .ENC_BIT0(enc0[2]), .ENC_BIT1(enc1[2]), .ENC_BIT2(enc2[2]), .OVFL(ovfl[2]));

  function automatic logic [14:0] mk(input int c4, input int c3, input int c2,
                                     input int c1, input int c0);
    return {3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic logic [14:0] act_codes(input int d);
    logic [14:0] r;
    for (int i = 0; i < 5; i++) r[3*i +: 3] = {enc2[d][i], enc1[d][i], enc0[d][i]};
    return r;
  endfunction

  function automatic vec_t mkv(input string nm, input bit rst, input int dut,
                               input logic [4:0] ctl, input logic [4:0] pre,
                               input logic [4:0] mw, input logic [4:0] lm,
                               input logic [14:0] codes, input logic [4:0] ov);
    vec_t v;
    v.name = nm; v.rst = rst; v.dut = dut; v.ctl = ctl; v.pre = pre;
    v.mw = mw; v.lm = lm; v.codes = codes; v.ov = ov;
    return v;
  endfunction

  task automatic add(input string nm, input bit rst, input int dut,
                     input logic [4:0] ctl, input logic [4:0] pre,
                     input logic [4:0] mw, input logic [4:0] lm,
                     input logic [14:0] codes, input logic [4:0] ov);
    vecs.push_back(mkv(nm, rst, dut, ctl, pre, mw, lm, codes, ov));
  endtask

  task automatic idle_inputs();
    ENCODE = 1'b0; DCFEB_IN_USE = 1'b0; SND_WIN = 1'b0; RESYNC_RST = 1'b0;
    L1ACFEB = 1'b0; PRE_LCT_OUT = '0; MTCH_WIN_0 = '0; L1A_MATCH = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  task automatic check_one();
    vec_t        v;
    logic [14:0] a;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    v = exp_q.pop_front();
    a = act_codes(v.dut);
    n_tests++;
    if (a !== v.codes) begin
      n_fail++;
      $display("FAIL %s codes (dut %0d): got %h want %h", v.name, v.dut, a, v.codes);
    end
    n_tests++;
    if (ovfl[v.dut] !== v.ov) begin
      n_fail++;
      $display("FAIL %s ovfl (dut %0d): got %b want %b", v.name, v.dut, ovfl[v.dut], v.ov);
    end
  endtask

  // Called at a negedge; returns at the negedge after the next posedge.
  task automatic run_vec(input vec_t v);
    if (v.rst) do_reset();
    ENCODE = v.ctl[4]; DCFEB_IN_USE = v.ctl[3]; SND_WIN = v.ctl[2];
    RESYNC_RST = v.ctl[1]; L1ACFEB = v.ctl[0];
    PRE_LCT_OUT = v.pre; MTCH_WIN_0 = v.mw; L1A_MATCH = v.lm;
    exp_q.push_back(v);
    @(posedge CLK);
    @(negedge CLK);
    check_one();
  endtask

  initial begin
    // Reset / pass-through (HOLD=2 instance, index 0)
    add("rst_idle",       1, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);
    add("pt_win",         0, 0, CD|CS,   5'b11111, 5'b10101, 5'b01010, mk(1,0,1,0,1), 5'b0);
    add("pt_match_l1a",   0, 0, CD|CL,   5'b11111, 5'b10101, 5'b01010, mk(2,3,2,3,2), 5'b0);
    add("pt_pre_resync",  0, 0, CR,      5'b00011, 5'b11100, 5'b11100, mk(4,4,4,5,5), 5'b0);
    add("pt_dcfeb_force", 0, 0, CE|CD,   5'b00000, 5'b00000, 5'b11111, mk(1,1,1,1,1), 5'b0);
    // Encoding and same-cycle merge, HOLD=2
    add("enc3_c0",        1, 0, CE|CL,   5'b00010, 5'b00000, 5'b00010, mk(4,4,4,3,4), 5'b0);
    add("enc3_c1",        0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(4,4,4,3,4), 5'b0);
    add("enc3_c2",        0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);
    add("merge_c0",       0, 0, CE|CL,   5'b00001, 5'b00000, 5'b00000, mk(4,4,4,4,2), 5'b0);
    add("merge_c1",       0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(4,4,4,4,2), 5'b0);
    add("merge_c2",       0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);
    // Queuing, HOLD=3 (index 1)
    add("queue_t0",       1, 1, CE,      5'b00100, 5'b00000, 5'b00000, mk(0,0,1,0,0), 5'b0);
    add("queue_t1",       0, 1, CE|CL,   5'b00000, 5'b00000, 5'b00000, mk(4,4,1,4,4), 5'b0);
    add("queue_t2",       0, 1, CE,      5'b00000, 5'b00000, 5'b00000, mk(4,4,1,4,4), 5'b0);
    add("queue_t3",       0, 1, CE,      5'b00000, 5'b00000, 5'b00000, mk(4,4,4,4,4), 5'b0);
    add("queue_t4",       0, 1, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,4,0,0), 5'b0);
    add("queue_t5",       0, 1, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,4,0,0), 5'b0);
    add("queue_t6",       0, 1, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);
    // Overrun then resync, HOLD=4 (index 2)
    add("ovr_t0",         1, 2, CE,      5'b01000, 5'b00000, 5'b00000, mk(0,1,0,0,0), 5'b00000);
    add("ovr_t1",         0, 2, CE,      5'b01000, 5'b00000, 5'b00000, mk(0,1,0,0,0), 5'b00000);
    add("ovr_t2",         0, 2, CE,      5'b01000, 5'b00000, 5'b00000, mk(0,1,0,0,0), 5'b01000);
    add("ovr_t3",         0, 2, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,1,0,0,0), 5'b01000);
    add("ovr_requeued",   0, 2, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,1,0,0,0), 5'b01000);
    add("resync_c0",      0, 2, CE|CR,   5'b00000, 5'b00000, 5'b00000, mk(7,7,7,7,7), 5'b00000);
    add("resync_c1",      0, 2, CE,      5'b00000, 5'b00000, 5'b00000, mk(7,7,7,7,7), 5'b00000);
    add("resync_c2",      0, 2, CE,      5'b00000, 5'b00000, 5'b00000, mk(7,7,7,7,7), 5'b00000);
    add("resync_c3",      0, 2, CE,      5'b00000, 5'b00000, 5'b00000, mk(7,7,7,7,7), 5'b00000);
    add("resync_done",    0, 2, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b00000);
    // Mode change mid-hold, HOLD=4: pass-through aborts hold and drops pending L1A
    add("mode_m0",        1, 2, CE,      5'b11111, 5'b00000, 5'b00000, mk(1,1,1,1,1), 5'b0);
    add("mode_m1",        0, 2, CE|CL,   5'b00000, 5'b00000, 5'b00000, mk(1,1,1,1,1), 5'b0);
    add("mode_pt",        0, 2, CI,      5'b10000, 5'b00000, 5'b00000, mk(1,0,0,0,0), 5'b0);
    add("mode_back",      0, 2, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);
    // Orphan match on ch4, HOLD=2
    add("orphan_t0",      1, 0, CE,      5'b00000, 5'b00000, 5'b10000, mk(0,0,0,0,0), 5'b0);
    add("orphan_t1",      0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);
    add("orphan_t2",      0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);
    add("orphan_l1a",     0, 0, CE|CL,   5'b00000, 5'b00000, 5'b00000, mk(5,4,4,4,4), 5'b0);
    add("orphan_hold",    0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(5,4,4,4,4), 5'b0);
    add("orphan_done",    0, 0, CE,      5'b00000, 5'b00000, 5'b00000, mk(0,0,0,0,0), 5'b0);

    idle_inputs();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Async reset in the middle of a hold with OVFL set (HOLD=4)
    run_vec(mkv("arst_pre0", 1, 2, CE, 5'b11111, 5'b0, 5'b0, mk(1,1,1,1,1), 5'b00000));
    run_vec(mkv("arst_pre1", 0, 2, CE, 5'b11111, 5'b0, 5'b0, mk(1,1,1,1,1), 5'b00000));
    run_vec(mkv("arst_pre2", 0, 2, CE, 5'b11111, 5'b0, 5'b0, mk(1,1,1,1,1), 5'b11111));
    PRE_LCT_OUT = '0;
    #2;
    RST_N = 1'b0;
    #1;
    n_tests++;
    if (act_codes(2) !== 15'd0 || ovfl[2] !== 5'd0) begin
      n_fail++;
      $display("FAIL arst_async: codes %h ovfl %b, want 0 and 0", act_codes(2), ovfl[2]);
    end
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    run_vec(mkv("arst_after0", 0, 2, CE, 5'b0, 5'b0, 5'b0, mk(0,0,0,0,0), 5'b0));
    run_vec(mkv("arst_after1", 0, 2, CE, 5'b0, 5'b0, 5'b0, mk(0,0,0,0,0), 5'b0));

    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
